fpadd_seq: RTL and testbench
============================

Name: fpadd_seq

Overview:
- Multi-cycle sequencer for the minifloat adder datapath.
- Accepts two 8-bit minifloat operands and orders them by magnitude.
- Drives the external alignment shifter (SHIFT) with exponent difference and smaller fraction, captures the aligned significand, then adds/subtracts, normalises one bit per cycle, packs the result.
- Sits between the processor's operand registers and the SHIFT instance; START/BUSY/DONE handshake.

Parameters:
- None. Format fixed: bit7 sign, bits[6:4] exponent (bias 3), bits[3:0] fraction. Exponent 0 = zero (fraction ignored). Valid nonzero exponents 1..7. Value = (-1)^s * 1.frac * 2^(exp-3).

Ports:
- CLK  in  1  clock, all state changes on rising edge
- RST  in  1  synchronous, active-high reset
- START  in  1  request; sampled only in IDLE or DONE state
- A  in  8  operand A, sampled with START
- B  in  8  operand B, sampled with START
- SH_FRAC  in  6  aligned significand returned by SHIFT (combinational from SH_* outputs)
- SH_EXP_DIFF  out  5  shift amount to SHIFT, 0..7, upper two bits 0
- SH_S_FRAC  out  4  fraction of smaller-magnitude operand to SHIFT
- BUSY  out  1  high in CMP, SHIFT, ADD, NORM
- DONE  out  1  one-cycle pulse, RESULT valid
- RESULT  out  8  packed sum, held until the next DONE
- OVF  out  1  overflow flag, valid with DONE, held with RESULT
- UNF  out  1  underflow flag, valid with DONE, held with RESULT

Behaviour:
- Reset: state IDLE; BUSY, DONE, RESULT, OVF, UNF, SH_EXP_DIFF, SH_S_FRAC all 0. Reset mid-operation aborts with no DONE.
- SHIFT contract: SH_FRAC = {1,SH_S_FRAC,0} >> SH_EXP_DIFF, zero-filled; shift 6 or 7 gives 0.
- IDLE/DONE, START=1 at edge k: latch A and B, go to CMP. START in any other state is ignored.
- CMP (k+1):
  - If either exponent is 0, RESULT = the other operand (0x00 if both are zero), go to DONE.
  - Otherwise L = operand with larger {exp,frac}; A wins ties.
  - Register SH_EXP_DIFF = expL - expS and SH_S_FRAC = fracS. Go to SHIFT.
- SHIFT (k+2): capture ALN = SH_FRAC, go to ADD.
- ADD (k+3):
  - Signs equal: SUM[6:0] = {1,fracL,0} + ALN.
  - Signs differ: SUM = {1,fracL,0} - ALN (never negative).
  - Result sign = sign of L. EXP = expL.
  - If SUM = 0: RESULT 0x00 (sign 0), go to DONE. Otherwise go to NORM.
- NORM: one action per cycle.
  - SUM[6]=1: if EXP=7, overflow (RESULT = {s,111,1111}, OVF=1, go to DONE); else SUM>>=1, EXP+=1.
  - SUM[6]=0 and SUM[5]=1: RESULT = {s, EXP, SUM[4:1]} (truncate), go to DONE.
  - SUM[6:5]=00: if EXP=1, underflow (RESULT 0x00, UNF=1, go to DONE); else SUM<<=1, EXP-=1.
- DONE state: DONE=1 for exactly one cycle, BUSY=0. Returns to IDLE unless START is accepted.
- OVF/UNF are cleared when a new operation is accepted.
- Latency: DONE at cycle k+5+n, where n = number of NORM shift steps. Zero-operand case: DONE at k+2. Exact cancellation: DONE at k+4.

Test Plan:
- A=0x38 (1.5), B=0x30 (1.0), START at k -> SH_EXP_DIFF=0 and SH_S_FRAC=0 in SHIFT cycle; one right shift; DONE at k+6, RESULT=0x44 (2.5), OVF=UNF=0.
- A=0x30, B=0xB0 -> exact cancellation; DONE at k+4, RESULT=0x00, flags 0.
- A=0x30, B=0xAF (-0.96875) -> SH_EXP_DIFF=1, SH_S_FRAC=0xF, SH_FRAC=0x1F; SUM=1; two left shifts then underflow at EXP=1; DONE at k+7, RESULT=0x00, UNF=1.
- A=0x7F, B=0x7F -> carry at EXP=7; DONE at k+5, RESULT=0x7F, OVF=1. Then A=0x70, B=0x10 -> SH_EXP_DIFF=6, SH_FRAC=0; RESULT=0x70, OVF now 0.
- A=0x00, B=0xC5 -> DONE at k+2, RESULT=0xC5. START pulses during BUSY of a following op are ignored: exactly one DONE.
- RST asserted in NORM -> next cycle BUSY=0, no DONE, all outputs 0. Next START completes normally. Back-to-back START in the DONE cycle is accepted: BUSY=1 on the following cycle.

Source files
------------

// File: rtl/fpadd_seq.sv
// Multi-cycle sequencer for the 8-bit minifloat adder (1 sign, 3 exp bias 3, 4 frac).
// Orders operands, drives the external alignment shifter, adds, normalises one bit per cycle.
module fpadd_seq (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic [5:0] SH_FRAC,
    output logic [4:0] SH_EXP_DIFF,
    output logic [3:0] SH_S_FRAC,
    output logic       BUSY,
    output logic       DONE,
    output logic [7:0] RESULT,
    output logic       OVF,
    output logic       UNF
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMP, S_SHIFT, S_ADD, S_NORM, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  a_q, a_d, b_q, b_d;
    logic [5:0]  aln_q, aln_d;
    logic [6:0]  sum_q, sum_d;
    logic [2:0]  exp_q, exp_d;
    logic        sign_q, sign_d;
    logic [7:0]  result_q, result_d;
    logic        ovf_q, ovf_d, unf_q, unf_d;
    logic [2:0]  diff_q, diff_d;
    logic [3:0]  sfrac_q, sfrac_d;

    // Operand ordering is derived from the held operands so ADD can reuse it.
    logic        a_wins;
    logic [7:0]  op_l, op_s;
    logic [6:0]  sig_l, sum_calc;

    always_comb begin
        a_wins   = (a_q[6:0] >= b_q[6:0]);
        op_l     = a_wins ? a_q : b_q;
        op_s     = a_wins ? b_q : a_q;
        sig_l    = {2'b01, op_l[3:0], 1'b0};
        sum_calc = (a_q[7] == b_q[7]) ? (sig_l + {1'b0, aln_q})
                                      : (sig_l - {1'b0, aln_q});
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        aln_d    = aln_q;
        sum_d    = sum_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        diff_d   = diff_q;
        sfrac_d  = sfrac_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (START) begin
                    a_d     = A;
                    b_d     = B;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    state_d = S_CMP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CMP: begin
                if (a_q[6:4] == 3'd0 && b_q[6:4] == 3'd0) begin
                    result_d = 8'h00;
                    state_d  = S_DONE;
                end else if (a_q[6:4] == 3'd0) begin
                    result_d = b_q;
                    state_d  = S_DONE;
                end else if (b_q[6:4] == 3'd0) begin
                    result_d = a_q;
                    state_d  = S_DONE;
                end else begin
                    diff_d  = op_l[6:4] - op_s[6:4];
                    sfrac_d = op_s[3:0];
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                aln_d   = SH_FRAC;
                state_d = S_ADD;
            end
            S_ADD: begin
                sum_d  = sum_calc;
                exp_d  = op_l[6:4];
                sign_d = op_l[7];
                if (sum_calc == 7'd0) begin
                    result_d = 8'h00;
                    state_d  = S_DONE;
                end else begin
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                if (sum_q[6]) begin
                    if (exp_q == 3'd7) begin
                        result_d = {sign_q, 7'h7F};
                        ovf_d    = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        sum_d = sum_q >> 1;
                        exp_d = exp_q + 3'd1;
                    end
                end else if (sum_q[5]) begin
                    // Hidden bit sits at SUM[5]; SUM[0] is dropped (truncation).
                    result_d = {sign_q, exp_q, sum_q[4:1]};
                    state_d  = S_DONE;
                end else if (exp_q == 3'd1) begin
                    result_d = 8'h00;
                    unf_d    = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    sum_d = sum_q << 1;
                    exp_d = exp_q - 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            aln_q    <= 6'd0;
            sum_q    <= 7'd0;
            exp_q    <= 3'd0;
            sign_q   <= 1'b0;
            result_q <= 8'h00;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            diff_q   <= 3'd0;
            sfrac_q  <= 4'd0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            aln_q    <= aln_d;
            sum_q    <= sum_d;
            exp_q    <= exp_d;
            sign_q   <= sign_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            diff_q   <= diff_d;
            sfrac_q  <= sfrac_d;
        end
    end

    assign SH_EXP_DIFF = {2'b00, diff_q};
    assign SH_S_FRAC   = sfrac_q;
    assign BUSY        = (state_q == S_CMP) || (state_q == S_SHIFT) ||
                         (state_q == S_ADD) || (state_q == S_NORM);
    assign DONE        = (state_q == S_DONE);
    assign RESULT      = result_q;
    assign OVF         = ovf_q;
    assign UNF         = unf_q;

endmodule

// File: tb/tb_fpadd_seq.sv
// Directed bench for fpadd_seq with a behavioural alignment shifter attached.
// Expected results and latencies are hand-computed from the minifloat format.
module tb_fpadd_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a_in, b_in;
    logic [5:0] sh_frac;
    logic [4:0] sh_exp_diff;
    logic [3:0] sh_s_frac;
    logic       busy, done, ovf, unf;
    logic [7:0] result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Alignment shifter: {1,frac,0} >> diff, zero-filled.
    assign sh_frac = {1'b1, sh_s_frac, 1'b0} >> sh_exp_diff;

    fpadd_seq dut (
        .CLK         (clk),
        .RST         (rst),
        .START       (start),
        .A           (a_in),
        .B           (b_in),
        .SH_FRAC     (sh_frac),
        .SH_EXP_DIFF (sh_exp_diff),
        .SH_S_FRAC   (sh_s_frac),
        .BUSY        (busy),
        .DONE        (done),
        .RESULT      (result),
        .OVF         (ovf),
        .UNF         (unf)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Called at a falling edge; leaves START low one falling edge later (cycle k+1).
    task automatic issue(input logic [7:0] a, input logic [7:0] b);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // exp_cnt: falling edges from now until DONE is seen.
    task automatic wait_done(input string tag, input int exp_cnt, input logic [7:0] e_res,
                             input logic e_ovf, input logic e_unf, input logic chk_sh,
                             input logic [4:0] e_diff, input logic [3:0] e_sfrac);
        int cnt = 0;
        while (!done && cnt < 40) begin
            @(negedge clk);
            cnt++;
            if (cnt == 1 && chk_sh) begin
                check_val({tag, "_shdiff"}, 32'(sh_exp_diff), 32'(e_diff));
                check_val({tag, "_shfrac"}, 32'(sh_s_frac), 32'(e_sfrac));
            end
        end
        check_val({tag, "_lat"}, 32'(cnt), 32'(exp_cnt));
        check_val({tag, "_res"}, 32'(result), 32'(e_res));
        check_val({tag, "_ovf"}, 32'(ovf), 32'(e_ovf));
        check_val({tag, "_unf"}, 32'(unf), 32'(e_unf));
        check_val({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n_done;
        rst   = 1'b1;
        start = 1'b0;
        a_in  = 8'h00;
        b_in  = 8'h00;
        repeat (3) @(negedge clk);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_res", 32'(result), 32'd0);
        check_val("rst_flags", 32'({ovf, unf}), 32'd0);
        check_val("rst_sh", 32'({sh_exp_diff, sh_s_frac}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1.5 + 1.0 = 2.5, one right shift, DONE at k+6
        issue(8'h38, 8'h30);
        check_val("add_busy", 32'(busy), 32'd1);
        wait_done("add", 5, 8'h44, 1'b0, 1'b0, 1'b1, 5'd0, 4'h0);
        @(negedge clk);
        check_val("add_pulse", 32'(done), 32'd0);

        // exact cancellation, DONE at k+4
        issue(8'h30, 8'hB0);
        wait_done("cancel", 3, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0, 4'h0);

        // 1.0 - 0.96875 underflows after two left shifts, DONE at k+7
        issue(8'h30, 8'hAF);
        wait_done("unf", 6, 8'h00, 1'b0, 1'b1, 1'b1, 5'd1, 4'hF);

        // carry out at max exponent, DONE at k+5
        issue(8'h7F, 8'h7F);
        wait_done("ovf", 4, 8'h7F, 1'b1, 1'b0, 1'b1, 5'd0, 4'hF);

        // shift of 6 aligns to zero; flags cleared by the new operation
        issue(8'h70, 8'h10);
        wait_done("far", 4, 8'h70, 1'b0, 1'b0, 1'b1, 5'd6, 4'h0);

        // zero operand passes the other through, DONE at k+2
        issue(8'h00, 8'hC5);
        wait_done("zero", 1, 8'hC5, 1'b0, 1'b0, 1'b0, 5'd0, 4'h0);

        // START pulses while busy are ignored
        @(negedge clk);
        issue(8'h38, 8'h30);
        a_in = 8'h7F; b_in = 8'h7F; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ign", 2, 8'h44, 1'b0, 1'b0, 1'b0, 5'd0, 4'h0);
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check_val("ign_onedone", 32'(n_done), 32'd0);

        // reset in NORM aborts the operation
        issue(8'h30, 8'hAF);
        repeat (3) @(negedge clk);
        check_val("abort_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("abort_busy", 32'(busy), 32'd0);
        check_val("abort_done", 32'(done), 32'd0);
        check_val("abort_res", 32'(result), 32'd0);
        check_val("abort_flags", 32'({ovf, unf}), 32'd0);
        check_val("abort_sh", 32'({sh_exp_diff, sh_s_frac}), 32'd0);
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check_val("abort_nodone", 32'(n_done), 32'd0);

        // normal operation after abort, then back-to-back START in the DONE cycle
        issue(8'h38, 8'h30);
        wait_done("post", 5, 8'h44, 1'b0, 1'b0, 1'b0, 5'd0, 4'h0);
        issue(8'h00, 8'hC5);
        check_val("b2b_busy", 32'(busy), 32'd1);
        wait_done("b2b", 1, 8'hC5, 1'b0, 1'b0, 1'b0, 5'd0, 4'h0);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
